regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single write port of the Regs register file between two writeback requesters:
//  src0 = ALU result, src1 = memory load data.
//  Each source owns a one-entry holding register with valid/ready handshake.
//  A priority arbiter with a starvation counter picks one held write per cycle and drives
//  registered L_S/Wt_addr/Wt_data into Regs.
//  Sits between the execute/memory stages and Regs in the AAI_CPU datapath.
// PARAMETERS
//  AW          5   register address width (32 GPRs)
//  DW          32  register data width
//  STARVE_LIM  3   consecutive src0 losses before src0 is forced to win (1..15)
// PORTS
//  clk          in   1   clock; all state changes on rising edge
//  rst          in   1   asynchronous, active-high reset
//  req0_valid   in   1   ALU write request
//  req0_ready   out  1   holding register 0 can accept this cycle
//  req0_addr    in   AW  destination register
//  req0_data    in   DW  write data
//  req1_valid   in   1   load write request
//  req1_ready   out  1   holding register 1 can accept this cycle
//  req1_addr    in   AW  destination register
//  req1_data    in   DW  write data
//  L_S          out  1   Regs write enable (registered)
//  Wt_addr      out  AW  Regs write address (registered)
//  Wt_data      out  DW  Regs write data (registered)
//  wb_src       out  2   state: 00 IDLE, 01 WR0, 10 WR1 (source of the current L_S cycle)
// BEHAVIOUR
//  Reset: both holds empty, starve_cnt=0, L_S=0, Wt_addr=0, Wt_data=0, wb_src=IDLE.
//   Reset is asynchronous; any accepted but unwritten data is discarded.
//  Accept: on an edge with reqN_valid && reqN_ready, holdN captures addr/data and becomes full.
//   reqN_ready = !holdN_full || grantN (combinational); back-to-back accepts give 1 write/cycle/src.
//  Arbitration (combinational, over full holds):
//   - only one hold full -> it wins;
//   - both full -> src1 wins unless starve_cnt==STARVE_LIM, in which case src0 wins.
//   starve_cnt increments when hold0 is full and not granted; clears on grant0; saturates at STARVE_LIM.
//  Grant edge: the winning hold is cleared (or reloaded if a new accept arrives on the same edge).
//   The output register loads Wt_addr/Wt_data; wb_src becomes WR0 or WR1.
//   With no grant: L_S=0, wb_src=IDLE, Wt_addr/Wt_data hold their previous values.
//  Latency: accept at edge N -> L_S high in cycle N+1..N+2 -> Regs writes at edge N+2.
//  Address 0: accepted and granted normally, but L_S stays 0; wb_src still shows the source.
//  Same address in both holds: writes go out in grant order, so the last write wins in Regs.
//  FSM: IDLE->WR0/WR1 on grant; WRx->WRy on the next grant; any state->IDLE when there is no grant.
// CONFIGURATION
//  `REGWB_FWD_EN defined:
//   - adds inputs rd_addr_a/rd_addr_b [AW] and outputs fwd_hit_a/b [1], fwd_data_a/b [DW];
//   - fwd_hit_x=1 iff L_S && Wt_addr==rd_addr_x && rd_addr_x!=0; fwd_data_x=Wt_data, else 0.
//   - This covers the same-cycle write/read case in Regs.
//  `REGWB_FWD_EN undefined: these ports are absent and there is no forwarding logic.
// STRUCTURE
//  regwb_pkg: REGWB_AW=5, REGWB_DW=32, wb_src encodings IDLE/WR0/WR1.
//  Sub-module regwb_hold: one-entry holding register (valid/ready in, full/addr/data out,
//   clr input); instantiated twice. Arbiter, starve counter and output stage live in the top.
// TESTING
//  1 Reset: rst=1 mid-stream with both holds full -> outputs 0, readies 1, no L_S afterwards.
//  2 Single write: req0 addr=5 data=a5a5a5a5 at edge N -> L_S=1, Wt_addr=5,
//    Wt_data=a5a5a5a5, wb_src=01 after edge N+1.
//  3 Conflict: req0(6,55aa55aa) and req1(7,12345678) on the same edge -> src1 written first,
//    then src0 on the next cycle.
//  4 Starvation: req1 valid every cycle, req0 held -> after 3 src1 grants, src0 is granted;
//    starve_cnt returns to 0.
//  5 Zero address: req1 addr=0 data=aaaa5555 -> wb_src=10 with L_S=0; Regs r0 reads 0.
//  6 Forwarding (`REGWB_FWD_EN): rd_addr_a=5 during the L_S cycle for addr 5 ->
//    fwd_hit_a=1, fwd_data_a=a5a5a5a5; rd_addr_a=0 -> fwd_hit_a=0.

Source files
------------

// File: rtl/regwb_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths and
// writeback source encodings.
package regwb_pkg;

    localparam int REGWB_AW = 5;
    localparam int REGWB_DW = 32;

    typedef enum logic [1:0] {
        WB_IDLE = 2'b00,
        WB_WR0  = 2'b01,
        WB_WR1  = 2'b10
    } wb_src_e;

    // A write to r0 is accepted but never enabled toward Regs.
    function automatic logic addr_writable(input logic [REGWB_AW-1:0] addr);
        return (addr != {REGWB_AW{1'b0}});
    endfunction

endpackage

// File: rtl/regwb_if.sv
// Writeback bus between the execute/memory requesters and the arbiter, plus the
// registered write port toward Regs.
interface regwb_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          L_S;
    logic [AW-1:0] Wt_addr;
    logic [DW-1:0] Wt_data;
    logic [1:0]    wb_src;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output L_S, Wt_addr, Wt_data, wb_src
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  L_S, Wt_addr, Wt_data, wb_src
    );
endinterface

// File: rtl/regwb_hold.sv
// One-entry holding register with valid/ready input; can reload on the same edge
// it is drained by a grant.
module regwb_hold #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_clr,
    output logic          o_ready,
    output logic          o_full,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data
);
    logic          r_full;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    assign o_ready = !r_full || i_clr;
    assign o_full  = r_full;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

    // Capture on accept, otherwise drain on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_addr <= {AW{1'b0}};
            r_data <= {DW{1'b0}};
        end else if (i_valid && o_ready) begin
            r_full <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end else begin
            r_full <= r_full;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (src0) and load (src1) writebacks onto the single Regs write port.
// Optional same-cycle read forwarding is enabled with `REGWB_FWD_EN.
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int AW         = REGWB_AW,
    parameter int DW         = REGWB_DW,
    parameter int STARVE_LIM = 3
) (
    input  logic          clk,
    input  logic          rst,
    regwb_if.slave        bus
`ifdef REGWB_FWD_EN
    ,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          fwd_hit_a,
    output logic          fwd_hit_b,
    output logic [DW-1:0] fwd_data_a,
    output logic [DW-1:0] fwd_data_b
`endif
);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic          w_full0, w_full1, w_ready0, w_ready1;
    logic [AW-1:0] w_addr0, w_addr1, w_win_addr;
    logic [DW-1:0] w_data0, w_data1, w_win_data;
    logic          w_grant0, w_grant1, w_grant;
    logic [3:0]    r_starve;
    wb_src_e       r_state, w_state_nxt;
    logic          r_ls;
    logic [AW-1:0] r_wt_addr;
    logic [DW-1:0] r_wt_data;

    regwb_hold #(.AW(AW), .DW(DW)) u_hold0 (
        .clk(clk), .rst(rst),
        .i_valid(bus.req0_valid), .i_addr(bus.req0_addr), .i_data(bus.req0_data),
        .i_clr(w_grant0), .o_ready(w_ready0), .o_full(w_full0),
        .o_addr(w_addr0), .o_data(w_data0)
    );

    regwb_hold #(.AW(AW), .DW(DW)) u_hold1 (
        .clk(clk), .rst(rst),
        .i_valid(bus.req1_valid), .i_addr(bus.req1_addr), .i_data(bus.req1_data),
        .i_clr(w_grant1), .o_ready(w_ready1), .o_full(w_full1),
        .o_addr(w_addr1), .o_data(w_data1)
    );

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;

    // Loads win conflicts unless the ALU has lost STARVE_LIM times in a row.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_full0 && w_full1) begin
            if (r_starve == LIM) begin
                w_grant0 = 1'b1;
            end else begin
                w_grant1 = 1'b1;
            end
        end else begin
            w_grant0 = w_full0;
            w_grant1 = w_full1;
        end
    end

    assign w_grant    = w_grant0 || w_grant1;
    assign w_win_addr = w_grant0 ? w_addr0 : w_addr1;
    assign w_win_data = w_grant0 ? w_data0 : w_data1;

    // Starvation counter: counts src0 losses while full, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= 4'd0;
        end else if (w_grant0) begin
            r_starve <= 4'd0;
        end else if (w_full0 && (r_starve != LIM)) begin
            r_starve <= r_starve + 4'd1;
        end else begin
            r_starve <= r_starve;
        end
    end

    // Writeback state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state follows the grant of the current cycle.
    always_comb begin
        w_state_nxt = WB_IDLE;
        case ({w_grant1, w_grant0})
            2'b01:   w_state_nxt = WB_WR0;
            2'b10:   w_state_nxt = WB_WR1;
            default: w_state_nxt = WB_IDLE;
        endcase
    end

    // Registered Regs write port; address/data hold their value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ls      <= 1'b0;
            r_wt_addr <= {AW{1'b0}};
            r_wt_data <= {DW{1'b0}};
        end else if (w_grant) begin
            r_ls      <= (w_win_addr != {AW{1'b0}});
            r_wt_addr <= w_win_addr;
            r_wt_data <= w_win_data;
        end else begin
            r_ls      <= 1'b0;
            r_wt_addr <= r_wt_addr;
            r_wt_data <= r_wt_data;
        end
    end

    assign bus.L_S     = r_ls;
    assign bus.Wt_addr = r_wt_addr;
    assign bus.Wt_data = r_wt_data;
    assign bus.wb_src  = r_state;

`ifdef REGWB_FWD_EN
    // Bypass the write that Regs performs at the end of this cycle.
    assign fwd_hit_a  = r_ls && (r_wt_addr == rd_addr_a) && (rd_addr_a != {AW{1'b0}});
    assign fwd_hit_b  = r_ls && (r_wt_addr == rd_addr_b) && (rd_addr_b != {AW{1'b0}});
    assign fwd_data_a = fwd_hit_a ? r_wt_data : {DW{1'b0}};
    assign fwd_data_b = fwd_hit_b ? r_wt_data : {DW{1'b0}};
`endif
endmodule
